// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and hex-to-segment decode for the scan display
package seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low pattern, bit order g..a.
  function automatic logic [6:0] hex2seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational nibble to seven-segment decoder
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex2seg(nibble);

endmodule

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - eight-digit multiplexed display with PWM, blanking and frame-synced update
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int PRESCALE = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic        load,
  input  logic        blank_lz,
  input  logic [3:0]  bright,
  input  logic [7:0]  dp,
  output logic        frame,
  output logic [7:0]  SEG,
  output logic [7:0]  AN
);

  localparam int CNT_W   = $clog2(PRESCALE);
  localparam int PWM_DIV = PRESCALE / 16;

  logic [CNT_W-1:0] slot_cnt;
  logic [CNT_W-1:0] sub_cnt;
  logic [3:0]       pwm_cnt;
  logic [2:0]       digit;
  logic [31:0]      shadow;
  logic [31:0]      pending;
  logic             pend_valid;

  logic [3:0] nibble;
  logic [6:0] seg7;
  logic       lz_blank;
  logic       lit;
  logic       slot_end;
  logic       frame_start;

  assign nibble      = 4'(shadow >> {digit, 2'b00});
  assign slot_end    = (slot_cnt == CNT_W'(PRESCALE - 1));
  assign frame_start = slot_end && (digit == 3'd7);

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (seg7)
  );

  // A digit is a leading zero when it and every digit to its left are zero.
  always_comb begin
    lz_blank = 1'b0;
    if (blank_lz && (digit != 3'd0))
      lz_blank = ((shadow >> {digit, 2'b00}) == 32'd0);
  end

  assign lit = (pwm_cnt <= bright) && !lz_blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt   <= '0;
      sub_cnt    <= '0;
      pwm_cnt    <= '0;
      digit      <= '0;
      shadow     <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
      SEG        <= SEG_OFF;
      AN         <= AN_OFF;
      frame      <= 1'b0;
    end else begin
      if (slot_end) begin
        slot_cnt <= '0;
        sub_cnt  <= '0;
        pwm_cnt  <= '0;
        digit    <= digit + 3'd1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
        if (sub_cnt == CNT_W'(PWM_DIV - 1)) begin
          sub_cnt <= '0;
          pwm_cnt <= pwm_cnt + 4'd1;
        end else begin
          sub_cnt <= sub_cnt + 1'b1;
        end
      end

      // A load on the frame-start edge stays pending; the transfer takes the older word.
      if (frame_start && pend_valid)
        shadow <= pending;
      if (load) begin
        pending    <= data;
        pend_valid <= 1'b1;
      end else if (frame_start) begin
        pend_valid <= 1'b0;
      end

      AN    <= lit ? ~(8'b1 << digit) : AN_OFF;
      SEG   <= lit ? {~dp[digit], seg7} : SEG_OFF;
      frame <= (digit == 3'd0) && (slot_cnt == '0);
    end
  end

endmodule
